// File: rtl/exception_arbiter.sv
// exception_arbiter
//
// Chooses the next handler entry for the CPU. Asynchronous device interrupt
// lines are synchronized, qualified by the PSW interrupt enable and mask, and
// priority-encoded (highest index wins). Synchronous exceptions (priority
// 16..31) always win over interrupts and may replace a pending interrupt
// before it is acknowledged. An accepted entry produces a single-cycle PSW
// write strobe carrying the new priority.
//
// Handshake: entryRequest/entryPriority are held stable while the entry is
// pending; the CPU accepts by pulsing entryAcknowledge in any pending cycle
// (valid/ready style: the transfer happens on the rising edge where both
// entryRequest and entryAcknowledge are high). Acknowledge outside the
// pending state has no effect.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   pswValue[31:0]          current PSW (27 vector, 23 IE, 15:0 mask)
//   interruptRequests[15:0] async level IRQ lines, line n = priority n
//   exceptionValid          synchronous exception raised this cycle
//   exceptionCode[4:0]      exception priority (16..31)
//   instructionBoundary     CPU can take an interrupt this cycle
//   entryRequest            handler entry pending
//   entryPriority[4:0]      priority of the pending entry (0 when not pending)
//   entryAcknowledge        CPU accepts the pending entry
//   pswWriteEnable          one-cycle PSW write strobe on handler entry
//   pswWriteDataSource      PSW data mux select (handler entry when strobing)
//   priorityWriteValue[4:0] priority written into the PSW on entry
//   handlerAddress[31:0]    handler entry PC, 0 while idle
//   busy                    state is not IDLE
//   debug_state[1:0]        current FSM state (IDLE=0, PENDING=1, COMMIT=2)

`ifndef PSW_WRITE_DATA_SOURCE_WIDTH
`define PSW_WRITE_DATA_SOURCE_WIDTH 2
`endif
`ifndef PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY
`define PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY `PSW_WRITE_DATA_SOURCE_WIDTH'(1)
`endif

module exception_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [31:0]                             pswValue,
    input  logic [15:0]                             interruptRequests,
    input  logic                                    exceptionValid,
    input  logic [4:0]                              exceptionCode,
    input  logic                                    instructionBoundary,
    output logic                                    entryRequest,
    output logic [4:0]                              entryPriority,
    input  logic                                    entryAcknowledge,
    output logic                                    pswWriteEnable,
    output logic [`PSW_WRITE_DATA_SOURCE_WIDTH-1:0] pswWriteDataSource,
    output logic [4:0]                              priorityWriteValue,
    output logic [31:0]                             handlerAddress,
    output logic                                    busy,
    output logic [1:0]                              debug_state
);

    // Fewer than two flops would not protect against metastability.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] sync_q [STAGES];
    logic [4:0]  latched_priority;
    logic        latched_vector;
    logic [15:0] eligible;
    logic [3:0]  winner;
    logic        unused_bits;

    function automatic logic [31:0] vector_address(input logic vector_bit);
        return vector_bit ? 32'hC000_0004 : 32'hE000_0004;
    endfunction

    function automatic logic [3:0] highest_index(input logic [15:0] lines);
        logic [3:0] index;
        index = '0;
        for (int i = 0; i < 16; i++) begin
            if (lines[i]) index = 4'(i);
        end
        return index;
    endfunction

    assign eligible    = sync_q[STAGES-1] & pswValue[15:0] & {16{pswValue[23]}};
    assign winner      = highest_index(eligible);
    assign debug_state = state;

    // PSW fields this block does not look at, and the exception code MSB,
    // which is implied by the exception class.
    assign unused_bits = ^{pswValue[31:28], pswValue[26:24], pswValue[22:16], exceptionCode[4]};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            state              <= IDLE;
            latched_priority   <= '0;
            latched_vector     <= 1'b0;
            entryRequest       <= 1'b0;
            entryPriority      <= '0;
            pswWriteEnable     <= 1'b0;
            pswWriteDataSource <= '0;
            priorityWriteValue <= '0;
            handlerAddress     <= '0;
            busy               <= 1'b0;
        end else begin
            sync_q[0] <= interruptRequests;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];

            case (state)
                IDLE: begin
                    // Exceptions are synchronous to the instruction stream and
                    // cannot be masked or deferred to a boundary.
                    if (exceptionValid) begin
                        state            <= PENDING;
                        latched_priority <= {1'b1, exceptionCode[3:0]};
                        latched_vector   <= pswValue[27];
                        entryRequest     <= 1'b1;
                        entryPriority    <= {1'b1, exceptionCode[3:0]};
                        handlerAddress   <= vector_address(pswValue[27]);
                        busy             <= 1'b1;
                    end else if (instructionBoundary && (|eligible)) begin
                        state            <= PENDING;
                        latched_priority <= {1'b0, winner};
                        latched_vector   <= pswValue[27];
                        entryRequest     <= 1'b1;
                        entryPriority    <= {1'b0, winner};
                        handlerAddress   <= vector_address(pswValue[27]);
                        busy             <= 1'b1;
                    end
                end

                PENDING: begin
                    // The request is latched: a dropped IRQ does not cancel it.
                    if (entryAcknowledge) begin
                        state              <= COMMIT;
                        entryRequest       <= 1'b0;
                        entryPriority      <= '0;
                        pswWriteEnable     <= 1'b1;
                        pswWriteDataSource <= `PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY;
                        priorityWriteValue <= latched_priority;
                        handlerAddress     <= vector_address(latched_vector);
                    end else if (exceptionValid) begin
                        latched_priority <= {1'b1, exceptionCode[3:0]};
                        entryPriority    <= {1'b1, exceptionCode[3:0]};
                    end
                end

                COMMIT: begin
                    state              <= IDLE;
                    pswWriteEnable     <= 1'b0;
                    pswWriteDataSource <= '0;
                    priorityWriteValue <= '0;
                    handlerAddress     <= '0;
                    busy               <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_arbiter.sv
// Bench for exception_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model of the arbitration rules.

`ifndef PSW_WRITE_DATA_SOURCE_WIDTH
`define PSW_WRITE_DATA_SOURCE_WIDTH 2
`endif
`ifndef PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY
`define PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY `PSW_WRITE_DATA_SOURCE_WIDTH'(1)
`endif

module tb_exception_arbiter;

    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] ADDR_VEC1   = 32'hC000_0004;
    localparam logic [31:0] ADDR_VEC0   = 32'hE000_0004;
    localparam logic [31:0] PSW_IE_ALL  = 32'h0080_FFFF;
    localparam logic [31:0] PSW_IE_OFF  = 32'h0000_FFFF;
    localparam logic [31:0] PSW_VEC1    = 32'h0800_FFFF;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] psw = PSW_IE_ALL;
    logic [15:0] irq = '0;
    logic        exc = 1'b0;
    logic [4:0]  code = 5'd16;
    logic        boundary = 1'b0;
    logic        ack = 1'b0;

    logic                                    entryRequest;
    logic [4:0]                              entryPriority;
    logic                                    pswWriteEnable;
    logic [`PSW_WRITE_DATA_SOURCE_WIDTH-1:0] pswWriteDataSource;
    logic [4:0]                              priorityWriteValue;
    logic [31:0]                             handlerAddress;
    logic                                    busy;
    logic [1:0]                              debug_state;

    always #5 clock = ~clock;

    exception_arbiter #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock(clock),
        .reset(reset),
        .pswValue(psw),
        .interruptRequests(irq),
        .exceptionValid(exc),
        .exceptionCode(code),
        .instructionBoundary(boundary),
        .entryRequest(entryRequest),
        .entryPriority(entryPriority),
        .entryAcknowledge(ack),
        .pswWriteEnable(pswWriteEnable),
        .pswWriteDataSource(pswWriteDataSource),
        .priorityWriteValue(priorityWriteValue),
        .handlerAddress(handlerAddress),
        .busy(busy),
        .debug_state(debug_state)
    );

    int checks = 0;
    int errors = 0;
    int write_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pending / m_committing describe where the entry is; m_irq_hist holds
    // the IRQ levels sampled on the last SYNC_STAGES edges, oldest first.
    logic [4:0]  exp_q[$];
    logic [15:0] m_irq_hist[$];
    bit          model_valid = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_committing = 1'b0;
    logic [4:0]  m_prio = '0;
    logic        m_vec = 1'b0;

    always @(posedge clock) begin
        logic [15:0] visible;
        logic [15:0] allowed;
        logic [4:0]  best;
        if (reset) begin
            m_pending    = 1'b0;
            m_committing = 1'b0;
            m_prio       = '0;
            m_vec        = 1'b0;
            m_irq_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_irq_hist.push_back(16'h0);
            model_valid = 1'b1;
        end else if (model_valid) begin
            visible = m_irq_hist.pop_front();
            m_irq_hist.push_back(irq);
            allowed = psw[23] ? (visible & psw[15:0]) : 16'h0;
            best = 5'd0;
            for (int i = 15; i >= 0; i--) begin
                if (allowed[i]) begin
                    best = 5'(i);
                    break;
                end
            end
            if (m_committing) begin
                m_committing = 1'b0;
            end else if (m_pending) begin
                if (ack) begin
                    m_pending    = 1'b0;
                    m_committing = 1'b1;
                    exp_q.push_back(m_prio);
                end else if (exc) begin
                    m_prio = 5'd16 + 5'(code % 16);
                end
            end else begin
                if (exc) begin
                    m_pending = 1'b1;
                    m_prio    = 5'd16 + 5'(code % 16);
                    m_vec     = psw[27];
                end else if (boundary && allowed != 16'h0) begin
                    m_pending = 1'b1;
                    m_prio    = best;
                    m_vec     = psw[27];
                end
            end
        end
    end

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clock) begin
        if (model_valid) begin
            chk("entryRequest", 32'(entryRequest), 32'(m_pending));
            chk("entryPriority", 32'(entryPriority), m_pending ? 32'(m_prio) : 32'h0);
            chk("pswWriteEnable", 32'(pswWriteEnable), 32'(m_committing));
            chk("pswWriteDataSource", 32'(pswWriteDataSource),
                m_committing ? 32'(`PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY) : 32'h0);
            chk("priorityWriteValue", 32'(priorityWriteValue), m_committing ? 32'(m_prio) : 32'h0);
            chk("handlerAddress", handlerAddress,
                (m_pending || m_committing) ? (m_vec ? ADDR_VEC1 : ADDR_VEC0) : 32'h0);
            chk("busy", 32'(busy), 32'(m_pending || m_committing));
            if (pswWriteEnable === 1'b1) begin
                write_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_commit actual=unexpected write of %0d required=no write", priorityWriteValue);
                end else begin
                    chk("sb_commit", 32'(priorityWriteValue), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic settle();
        reset    = 1'b0;
        irq      = '0;
        boundary = 1'b0;
        exc      = 1'b0;
        ack      = 1'b0;
        code     = 5'd16;
        psw      = PSW_IE_ALL;
        repeat (SYNC_STAGES + 3) @(negedge clock);
    endtask

    task automatic raise_exception(input logic [4:0] c);
        exc  = 1'b1;
        code = c;
        @(negedge clock);
        exc  = 1'b0;
    endtask

    task automatic ack_and_expect(input string name, input logic [4:0] prio);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        chk({name, "_we"}, 32'(pswWriteEnable), 32'h1);
        chk({name, "_pwv"}, 32'(priorityWriteValue), 32'(prio));
        @(negedge clock);
        chk({name, "_we_drop"}, 32'(pswWriteEnable), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wc;
        repeat (3) @(negedge clock);
        chk("reset_req", 32'(entryRequest), 32'h0);
        chk("reset_we", 32'(pswWriteEnable), 32'h0);
        chk("reset_addr", handlerAddress, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // Two IRQs, boundary high: highest line wins after sync + latch.
        psw = PSW_IE_ALL; boundary = 1'b1; irq = 16'h0208;
        repeat (2) @(negedge clock);
        chk("irq_not_yet", 32'(entryRequest), 32'h0);
        @(negedge clock);
        chk("irq_req", 32'(entryRequest), 32'h1);
        chk("irq_prio", 32'(entryPriority), 32'd9);
        chk("irq_addr", handlerAddress, ADDR_VEC0);
        irq = '0; boundary = 1'b0;
        ack_and_expect("irq_commit", 5'd9);
        settle();

        // Exception ignores IE; vector bit selects the handler base.
        psw = PSW_IE_OFF; irq = 16'h0020; boundary = 1'b1;
        raise_exception(5'd21);
        chk("exc_req", 32'(entryRequest), 32'h1);
        chk("exc_prio", 32'(entryPriority), 32'd21);
        chk("exc_addr0", handlerAddress, ADDR_VEC0);
        ack_and_expect("exc_commit", 5'd21);
        psw = PSW_VEC1;
        raise_exception(5'd21);
        chk("exc_addr1", handlerAddress, ADDR_VEC1);
        ack_and_expect("exc_commit_v1", 5'd21);
        settle();

        // Exception replaces a pending interrupt.
        irq = 16'h0080; boundary = 1'b1;
        repeat (3) @(negedge clock);
        chk("pre_prio7", 32'(entryPriority), 32'd7);
        irq = '0; boundary = 1'b0;
        raise_exception(5'd18);
        chk("preempt_prio", 32'(entryPriority), 32'd18);
        ack_and_expect("preempt_commit", 5'd18);
        settle();

        // Masked line never requests until the mask bit is set.
        psw = 32'h0080_FFEF; irq = 16'h0010; boundary = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("masked_no_req", 32'(entryRequest), 32'h0);
        end
        psw = PSW_IE_ALL;
        @(negedge clock);
        chk("unmask_req", 32'(entryRequest), 32'h1);
        chk("unmask_prio", 32'(entryPriority), 32'd4);
        irq = '0; boundary = 1'b0;
        ack_and_expect("unmask_commit", 5'd4);
        settle();

        // Reset on the acknowledge edge aborts the entry without a write.
        raise_exception(5'd17);
        chk("abort_req", 32'(entryRequest), 32'h1);
        wc = write_count;
        ack = 1'b1; reset = 1'b1;
        @(negedge clock);
        ack = 1'b0; reset = 1'b0;
        chk("abort_we", 32'(pswWriteEnable), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge clock);
        chk("abort_no_write", 32'(write_count), 32'(wc));
        // Reset during the commit cycle.
        raise_exception(5'd17);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        chk("commit_we", 32'(pswWriteEnable), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("commit_rst_we", 32'(pswWriteEnable), 32'h0);
        chk("commit_rst_busy", 32'(busy), 32'h0);
        chk("commit_rst_addr", handlerAddress, 32'h0);
        settle();

        // Dropped IRQ does not cancel a pending request.
        irq = 16'h0004; boundary = 1'b1;
        repeat (3) @(negedge clock);
        chk("drop_prio", 32'(entryPriority), 32'd2);
        irq = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("drop_persist", 32'(entryRequest), 32'h1);
            chk("drop_persist_prio", 32'(entryPriority), 32'd2);
        end
        boundary = 1'b0;
        ack_and_expect("drop_commit", 5'd2);
        settle();

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) irq = 16'($urandom) & 16'($urandom);
            psw = {4'h0, 1'($urandom_range(0, 1)), 3'h0, 1'($urandom_range(0, 3) != 0),
                   7'h0, 16'($urandom)};
            exc      = ($urandom_range(0, 7) == 0);
            code     = 5'($urandom_range(16, 31));
            boundary = 1'($urandom_range(0, 1));
            ack      = ($urandom_range(0, 2) == 0);
            @(negedge clock);
        end
        settle();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
